// File: rtl/ma_decim_buffer.sv
// Keeps one of every decim+1 valid filter samples and queues the kept
// samples in a first-word-fall-through FIFO with a sticky overflow flag.
module ma_decim_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic signed [15:0]        d,
  input  logic                      d_valid,
  input  logic [2:0]                decim,
  output logic signed [15:0]        q,
  output logic                      q_valid,
  input  logic                      q_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]         sync;
  logic               rst_n;
  logic [2:0]         phase;
  logic [3:0]         m;
  logic               keep;
  logic               full;
  logic               push;
  logic               pop;
  logic               ovf_set;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic signed [15:0] mem [DEPTH];

  // Assert asynchronously, release two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b00;
    else          sync <= {sync[0], 1'b1};
  end

  assign rst_n = sync[1];

  assign m    = {1'b0, decim} + 4'd1;
  assign keep = d_valid &&
                (phase == 3'd0 || {1'b0, phase} >= m);

  assign full    = (count == FULL);
  assign q_valid = (count != '0);
  assign pop     = q_valid && q_ready;
  assign push    = keep && (!full || pop);
  assign ovf_set = keep && full && !pop;

  assign q = q_valid ? mem[rptr] : '0;

  // Out-of-range phase after a decim change forces a keep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 3'd0;
    end else if (d_valid) begin
      if (keep)
        phase <= (m == 4'd1) ? 3'd0 : 3'd1;
      else if ({1'b0, phase} == m - 4'd1)
        phase <= 3'd0;
      else
        phase <= phase + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_ma_decim_buffer.sv
// Directed bench for ma_decim_buffer: decimation, FIFO fill/full
// behaviour, overflow flag and reset handling.
module tb_ma_decim_buffer;

  logic               clk;
  logic               reset_n;
  logic signed [15:0] d;
  logic               d_valid;
  logic [2:0]         decim;
  logic signed [15:0] q;
  logic               q_valid;
  logic               q_ready;
  logic [3:0]         count;
  logic               overflow;
  logic               clr_ovf;

  int pass_cnt = 0;
  int total    = 0;

  ma_decim_buffer #(.DEPTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d        (d),
    .d_valid  (d_valid),
    .decim    (decim),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic signed [15:0] v, input logic dv,
                     input logic [2:0] dc, input logic rdy,
                     input logic clr);
    d       = v;
    d_valid = dv;
    decim   = dc;
    q_ready = rdy;
    clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    total++;
    if (q_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 ||
        q !== 16'sd0)
      $display("FAIL reset_state: qv=%b cnt=%0d ovf=%b q=%0d want 0/0/0/0",
               q_valid, count, overflow, q);
    else pass_cnt++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (q_valid !== 1'b0 || count !== 4'd0)
      $display("FAIL reset_sync_hold: qv=%b cnt=%0d want 0/0",
               q_valid, count);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_decim4;
    int nvalid;
    logic exp_v;
    nvalid = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(16'(k), 1'b1, 3'd3, 1'b1, 1'b0);
      exp_v = ((k - 1) % 4 == 0);
      total++;
      if (q_valid !== exp_v)
        $display("FAIL decim4_valid k=%0d: qv=%b want %b", k, q_valid, exp_v);
      else pass_cnt++;
      if (exp_v) begin
        nvalid++;
        total++;
        if (q !== 16'(k))
          $display("FAIL decim4_q k=%0d: q=%0d want %0d", k, q, k);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 10; i++) begin
      cyc(16'(99 + i), 1'b1, 3'd0, 1'b0, 1'b0);
      total++;
      if (count !== 4'((i > 8) ? 8 : i) || overflow !== (i >= 9) ||
          q !== 16'sd100)
        $display("FAIL ovf_fill i=%0d: cnt=%0d ovf=%b q=%0d want %0d/%b/100",
                 i, count, overflow, q, (i > 8) ? 8 : i, (i >= 9));
      else pass_cnt++;
    end
    cyc(16'sd0, 1'b0, 3'd0, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b0 || count !== 4'd8)
      $display("FAIL ovf_clear: ovf=%b cnt=%0d want 0/8", overflow, count);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] exp_q;
    for (int j = 1; j <= 10; j++) begin
      cyc(16'(199 + j), 1'b1, 3'd0, 1'b1, 1'b0);
      exp_q = (j < 8) ? 16'(100 + j) : 16'(200 + j - 8);
      total++;
      if (count !== 4'd8 || overflow !== 1'b0 || q !== exp_q)
        $display("FAIL b2b j=%0d: cnt=%0d ovf=%b q=%0d want 8/0/%0d",
                 j, count, overflow, q, exp_q);
      else pass_cnt++;
    end
    for (int j = 0; j < 8; j++) cyc(16'sd0, 1'b0, 3'd0, 1'b1, 1'b0);
    total++;
    if (count !== 4'd0 || q_valid !== 1'b0)
      $display("FAIL b2b_drain: cnt=%0d qv=%b want 0/0", count, q_valid);
    else pass_cnt++;
  endtask

  task automatic test_decim_switch;
    for (int k = 1; k <= 5; k++) begin
      cyc(16'(k), 1'b1, 3'd7, 1'b1, 1'b0);
      total++;
      if (q_valid !== (k == 1) || (k == 1 && q !== 16'sd1))
        $display("FAIL sw_m8 k=%0d: qv=%b q=%0d want %b", k, q_valid, q,
                 (k == 1));
      else pass_cnt++;
    end
    for (int k = 11; k <= 16; k++) begin
      cyc(16'(k), 1'b1, 3'd1, 1'b1, 1'b0);
      total++;
      if (q_valid !== (k % 2 == 1) || (k % 2 == 1 && q !== 16'(k)))
        $display("FAIL sw_m2 k=%0d: qv=%b q=%0d want %b/%0d", k, q_valid, q,
                 (k % 2 == 1), k);
      else pass_cnt++;
    end
    cyc(16'sd0, 1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_min_sample;
    cyc(-16'sd32768, 1'b1, 3'd0, 1'b1, 1'b0);
    total++;
    if (q_valid !== 1'b1 || q !== -16'sd32768 || count !== 4'd1)
      $display("FAIL min_push: qv=%b q=%0d cnt=%0d want 1/-32768/1",
               q_valid, q, count);
    else pass_cnt++;
    cyc(16'sd0, 1'b0, 3'd0, 1'b1, 1'b0);
    total++;
    if (q_valid !== 1'b0 || count !== 4'd0)
      $display("FAIL min_pop: qv=%b cnt=%0d want 0/0", q_valid, count);
    else pass_cnt++;
  endtask

  task automatic test_set_wins;
    for (int i = 0; i < 8; i++) cyc(16'(300 + i), 1'b1, 3'd0, 1'b0, 1'b0);
    cyc(16'sd999, 1'b1, 3'd0, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b1 || count !== 4'd8 || q !== 16'sd300)
      $display("FAIL set_wins: ovf=%b cnt=%0d q=%0d want 1/8/300",
               overflow, count, q);
    else pass_cnt++;
    cyc(16'sd0, 1'b0, 3'd0, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b0)
      $display("FAIL set_wins_clr: ovf=%b want 0", overflow);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (q !== 16'(300 + i))
        $display("FAIL set_wins_data i=%0d: q=%0d want %0d", i, q, 300 + i);
      else pass_cnt++;
      cyc(16'sd0, 1'b0, 3'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) cyc(16'(40 + i), 1'b1, 3'd0, 1'b0, 1'b0);
    total++;
    if (count !== 4'd5)
      $display("FAIL rst_mid_fill: cnt=%0d want 5", count);
    else pass_cnt++;
    d_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    total++;
    if (q_valid !== 1'b0 || count !== 4'd0)
      $display("FAIL rst_mid_async: qv=%b cnt=%0d want 0/0", q_valid, count);
    else pass_cnt++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc(16'sd777, 1'b1, 3'd3, 1'b0, 1'b0);
    total++;
    if (q_valid !== 1'b1 || q !== 16'sd777 || count !== 4'd1)
      $display("FAIL rst_mid_first: qv=%b q=%0d cnt=%0d want 1/777/1",
               q_valid, q, count);
    else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    d       = '0;
    d_valid = 1'b0;
    decim   = 3'd0;
    q_ready = 1'b0;
    clr_ovf = 1'b0;
    test_reset;
    test_decim4;
    test_overflow;
    test_back_to_back;
    test_decim_switch;
    test_min_sample;
    test_set_wins;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
